// File: rtl/pixel_collector.sv
// Collects one iteration result per engine for a batch of raster pixels, acknowledges the batch
// with fin_flag, then streams it out in raster order with frame/line markers.
module pixel_collector #(
    parameter int NUM_ENGINES   = 8,
    parameter int ITER_WIDTH    = 8,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_ENGINES-1:0]            engine_done,
    input  logic [NUM_ENGINES*ITER_WIDTH-1:0] engine_iter,
    output logic                              fin_flag,
    output logic                              pix_valid,
    input  logic                              pix_ready,
    output logic [ITER_WIDTH-1:0]             pix_data,
    output logic                              pix_sof,
    output logic                              pix_eol,
    output logic                              overrun
);

    localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int IW = (NUM_ENGINES   > 1) ? $clog2(NUM_ENGINES)   : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(SCREEN_HEIGHT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_ENGINES - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_ENGINES-1:0]  cap_q, cap_d;
    logic [ITER_WIDTH-1:0]   capData_q [NUM_ENGINES];
    logic [ITER_WIDTH-1:0]   capData_d [NUM_ENGINES];
    logic [ITER_WIDTH-1:0]   outBuf_q  [NUM_ENGINES];
    logic [ITER_WIDTH-1:0]   outBuf_d  [NUM_ENGINES];
    logic [IW-1:0]           idx_q, idx_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic                    fin_q, fin_d;
    logic                    valid_q, valid_d;
    logic [ITER_WIDTH-1:0]   data_q, data_d;
    logic                    sof_q, sof_d;
    logic                    eol_q, eol_d;
    logic                    overrun_q, overrun_d;

    logic [NUM_ENGINES-1:0]  mergedCap;
    logic [ITER_WIDTH-1:0]   mergedData [NUM_ENGINES];
    logic [XW-1:0]           xAdv;
    logic [YW-1:0]           yAdv;

    // Control and output registers; synchronous reset drops any batch in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cap_q     <= '0;
            idx_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fin_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fin_q     <= fin_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            overrun_q <= overrun_d;
        end
    end

    // Data storage is qualified by cap_q/state_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_ENGINES; k++) begin
            capData_q[k] <= capData_d[k];
            outBuf_q[k]  <= outBuf_d[k];
        end
    end

    // Capture view including this cycle's done pulses; an already-held result always wins.
    always_comb begin
        mergedCap = cap_q | engine_done;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            mergedData[k] = cap_q[k] ? capData_q[k] : engine_iter[k*ITER_WIDTH +: ITER_WIDTH];
        end
    end

    // Screen position of the pixel following the one currently presented.
    always_comb begin
        xAdv = x_q + 1'b1;
        yAdv = y_q;
        if (x_q == X_LAST) begin
            xAdv = '0;
            yAdv = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cap_d     = mergedCap;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        fin_d     = 1'b0;
        valid_d   = valid_q;
        data_d    = data_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        overrun_d = overrun_q | (|(cap_q & engine_done));
        for (int k = 0; k < NUM_ENGINES; k++) begin
            capData_d[k] = mergedData[k];
            outBuf_d[k]  = outBuf_q[k];
        end

        case (state_q)
            IDLE: begin
                if (&mergedCap) begin
                    for (int k = 0; k < NUM_ENGINES; k++) begin
                        outBuf_d[k] = mergedData[k];
                    end
                    cap_d   = '0;
                    fin_d   = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                    valid_d = 1'b1;
                    data_d  = mergedData[0];
                    sof_d   = (x_q == '0) && (y_q == '0);
                    eol_d   = (x_q == X_LAST);
                end
            end
            STREAM: begin
                if (valid_q && pix_ready) begin
                    x_d = xAdv;
                    y_d = yAdv;
                    if (idx_q == IDX_LAST) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = outBuf_q[idx_q + 1'b1];
                        sof_d  = (xAdv == '0) && (yAdv == '0);
                        eol_d  = (xAdv == X_LAST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fin_flag  = fin_q;
    assign pix_valid = valid_q;
    assign pix_data  = data_q;
    assign pix_sof   = sof_q;
    assign pix_eol   = eol_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pixel_collector.sv
// Directed bench for pixel_collector on a tiny 8x2 screen with 4 engines.
module tb_pixel_collector;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 8;
    localparam int SH = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     engine_done = '0;
    logic [N*W-1:0]   engine_iter = '0;
    logic             fin_flag;
    logic             pix_valid;
    logic             pix_ready = 1'b1;
    logic [W-1:0]     pix_data;
    logic             pix_sof;
    logic             pix_eol;
    logic             overrun;

    int errors = 0;
    int checks = 0;

    pixel_collector #(
        .NUM_ENGINES(N),
        .ITER_WIDTH(W),
        .SCREEN_WIDTH(SW),
        .SCREEN_HEIGHT(SH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .engine_done(engine_done),
        .engine_iter(engine_iter),
        .fin_flag(fin_flag),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data(pix_data),
        .pix_sof(pix_sof),
        .pix_eol(pix_eol),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of done pulses with the four engine results packed engine 0 lowest.
    task automatic applyStimulus(input logic [N-1:0] mask, input int d0, input int d1,
                                 input int d2, input int d3);
        engine_done = mask;
        engine_iter = {W'(d3), W'(d2), W'(d1), W'(d0)};
        tick();
        engine_done = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        engine_done = '0;
        pix_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", pix_valid); end
        checks++; if (fin_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_fin: got %0b expected 0", fin_flag); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %0b expected 0", overrun); end
        checks++; if (pix_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_data: got %0d expected 0", pix_data); end
    endtask

    task automatic test_basic();
        int exp;
        test_reset();
        applyStimulus(4'b0001, 10, 11, 12, 13);
        checks++; if (fin_flag !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_fin0: got %0b expected 0", fin_flag); end
        applyStimulus(4'b0010, 10, 11, 12, 13);
        applyStimulus(4'b0100, 10, 11, 12, 13);
        checks++; if (fin_flag !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_fin2: got %0b expected 0", fin_flag); end
        applyStimulus(4'b1000, 10, 11, 12, 13);
        checks++; if (fin_flag !== 1'b1) begin errors++; $display("[TB] FAIL basic_fin: got %0b expected 1", fin_flag); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                checks++; if (fin_flag !== 1'b0) begin errors++; $display("[TB] FAIL basic_fin_pulse%0d: got %0b expected 0", i, fin_flag); end
            end
            exp = 10 + i;
            checks++; if (pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid%0d: got %0b expected 1", i, pix_valid); end
            checks++; if (pix_data !== W'(exp)) begin errors++; $display("[TB] FAIL basic_data%0d: got %0d expected %0d", i, pix_data, exp); end
            checks++; if (pix_sof !== (i == 0)) begin errors++; $display("[TB] FAIL basic_sof%0d: got %0b expected %0b", i, pix_sof, (i == 0)); end
            checks++; if (pix_eol !== 1'b0) begin errors++; $display("[TB] FAIL basic_eol%0d: got %0b expected 0", i, pix_eol); end
        end
        tick();
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained: got %0b expected 0", pix_valid); end
    endtask

    task automatic test_out_of_order();
        int exp;
        test_reset();
        applyStimulus(4'b0100, 0, 0, 22, 0);
        applyStimulus(4'b1001, 20, 0, 99, 23);
        checks++; if (fin_flag !== 1'b0) begin errors++; $display("[TB] FAIL ooo_early_fin: got %0b expected 0", fin_flag); end
        applyStimulus(4'b0010, 0, 21, 0, 0);
        checks++; if (fin_flag !== 1'b1) begin errors++; $display("[TB] FAIL ooo_fin: got %0b expected 1", fin_flag); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            exp = 20 + i;
            checks++; if (pix_data !== W'(exp)) begin errors++; $display("[TB] FAIL ooo_data%0d: got %0d expected %0d", i, pix_data, exp); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int exp;
        test_reset();
        applyStimulus(4'b1111, 30, 31, 32, 33);
        tick();
        pix_ready = 1'b0;
        applyStimulus(4'b1111, 40, 41, 42, 43);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            checks++; if (pix_data !== 8'd31 || pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold%0d: got %0d/%0b expected 31/1", c, pix_data, pix_valid); end
            checks++; if (fin_flag !== 1'b0) begin errors++; $display("[TB] FAIL bp_fin_blocked%0d: got %0b expected 0", c, fin_flag); end
        end
        pix_ready = 1'b1;
        tick();
        checks++; if (pix_data !== 8'd32) begin errors++; $display("[TB] FAIL bp_resume32: got %0d expected 32", pix_data); end
        tick();
        checks++; if (pix_data !== 8'd33) begin errors++; $display("[TB] FAIL bp_resume33: got %0d expected 33", pix_data); end
        tick();
        checks++; if (pix_valid !== 1'b0 || fin_flag !== 1'b0) begin errors++; $display("[TB] FAIL bp_bubble: got valid=%0b fin=%0b expected 0/0", pix_valid, fin_flag); end
        tick();
        checks++; if (fin_flag !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_fin: got %0b expected 1", fin_flag); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            exp = 40 + i;
            checks++; if (pix_data !== W'(exp)) begin errors++; $display("[TB] FAIL bp_next_data%0d: got %0d expected %0d", i, pix_data, exp); end
            checks++; if (pix_eol !== (i == 3)) begin errors++; $display("[TB] FAIL bp_next_eol%0d: got %0b expected %0b", i, pix_eol, (i == 3)); end
            checks++; if (pix_sof !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_sof%0d: got %0b expected 0", i, pix_sof); end
        end
        tick();
    endtask

    // Pixel p sits at x = p % 8, y = (p / 8) % 2 on the 8x2 screen.
    task automatic test_wrap();
        int p;
        test_reset();
        for (int b = 0; b < 5; b++) begin
            applyStimulus(4'b1111, 4*b, 4*b+1, 4*b+2, 4*b+3);
            checks++; if (fin_flag !== 1'b1) begin errors++; $display("[TB] FAIL wrap_fin%0d: got %0b expected 1", b, fin_flag); end
            for (int i = 0; i < 4; i++) begin
                if (i > 0) tick();
                p = 4*b + i;
                checks++; if (pix_data !== W'(p)) begin errors++; $display("[TB] FAIL wrap_data%0d: got %0d expected %0d", p, pix_data, p); end
                checks++; if (pix_sof !== (p % 16 == 0)) begin errors++; $display("[TB] FAIL wrap_sof%0d: got %0b expected %0b", p, pix_sof, (p % 16 == 0)); end
                checks++; if (pix_eol !== (p % 8 == 7)) begin errors++; $display("[TB] FAIL wrap_eol%0d: got %0b expected %0b", p, pix_eol, (p % 8 == 7)); end
            end
            tick();
            checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_bubble%0d: got %0b expected 0", b, pix_valid); end
        end
    endtask

    task automatic test_overrun();
        test_reset();
        applyStimulus(4'b0010, 0, 55, 0, 0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear: got %0b expected 0", overrun); end
        applyStimulus(4'b0010, 0, 99, 0, 0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %0b expected 1", overrun); end
        applyStimulus(4'b1101, 50, 77, 52, 53);
        checks++; if (fin_flag !== 1'b1 || pix_data !== 8'd50) begin errors++; $display("[TB] FAIL ovr_fin: got fin=%0b data=%0d expected 1/50", fin_flag, pix_data); end
        tick();
        checks++; if (pix_data !== 8'd55) begin errors++; $display("[TB] FAIL ovr_first_kept: got %0d expected 55", pix_data); end
        tick();
        tick();
        tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %0b expected 1", overrun); end
    endtask

    task automatic test_reset_mid_stream();
        test_reset();
        applyStimulus(4'b1111, 60, 61, 62, 63);
        tick();
        tick();
        checks++; if (pix_data !== 8'd62) begin errors++; $display("[TB] FAIL rst_pre: got %0d expected 62", pix_data); end
        reset = 1'b1;
        tick();
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0b expected 0", pix_valid); end
        reset = 1'b0;
        applyStimulus(4'b1111, 70, 71, 72, 73);
        checks++; if (pix_data !== 8'd70 || pix_sof !== 1'b1) begin errors++; $display("[TB] FAIL rst_restart: got data=%0d sof=%0b expected 70/1", pix_data, pix_sof); end
        tick();
        checks++; if (pix_data !== 8'd71 || pix_sof !== 1'b0) begin errors++; $display("[TB] FAIL rst_second: got data=%0d sof=%0b expected 71/0", pix_data, pix_sof); end
        tick();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_order();
        test_backpressure();
        test_wrap();
        test_overrun();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
